// File: rtl/wait_state_memory.sv
// Single-port register-file memory behind a req/ready handshake, with a fixed or
// LFSR-driven number of wait states before each one-cycle completion pulse.
module wait_state_memory #(
  parameter int           DATA_W      = 32,
  parameter int           ADDR_W      = 4,
  parameter int           DEPTH       = 16,
  parameter int           RANDOM_WAIT = 1,
  parameter int           FIXED_WAIT  = 2,
  parameter int           WAIT_W      = 3,
  parameter logic [7:0]   LFSR_SEED   = 8'hE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_i,
  input  logic                req_rnw_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic                req_ready_o,
  output logic [DATA_W-1:0]   req_rdata_o,
  output logic                req_err_o,
  output logic                busy_o,
  output logic [1:0]          dbg_state_o
);

  // Handshake: req_i is held high with stable fields until the one-cycle
  // req_ready_o pulse; fields are captured only in the accept (IDLE) cycle,
  // and dropping req_i while in WAIT abandons the transaction without effect.

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          lfsr_q;
  logic                rnw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       be_q;
  logic                accept;
  logic                addr_err;
  logic                mem_we;
  logic [WAIT_W-1:0]   wait_sel;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  // Free-running wait source, independent of traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign wait_sel = (RANDOM_WAIT != 0) ? lfsr_q[WAIT_W-1:0] : FIXED_WAIT[WAIT_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          cnt_d   = wait_sel;
          state_d = (wait_sel == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == WAIT_W'(1)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rnw_q   <= req_rnw_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  // Widened compare so DEPTH == 2**ADDR_W is representable.
  assign addr_err = ({1'b0, addr_q} >= DEPTH_X);
  assign mem_we   = (state_q == ST_RESP) && !rnw_q && !addr_err;

  // Storage has no reset; a write commits on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) begin
          mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    req_rdata_o = '0;
    if ((state_q == ST_RESP) && rnw_q && !addr_err) begin
      req_rdata_o = mem[addr_q];
    end
  end

  assign req_ready_o = (state_q == ST_RESP);
  assign req_err_o   = (state_q == ST_RESP) && addr_err;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
